// File: rtl/mem_io_pkg.sv
// Shared constants for the memory-mapped I/O controller: bus widths,
// register addresses, STATUS bit positions and the keyboard buffer states.
package mem_io_pkg;

  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 16;
  localparam int RAM_AW    = 14;
  localparam int RAM_DEPTH = 1 << RAM_AW;

  // Peripheral register addresses (RAM occupies 0x0000-0x3FFF)
  localparam logic [ADDR_W-1:0] ADDR_GPIO_OUT = 15'h4000;
  localparam logic [ADDR_W-1:0] ADDR_GPIO_IN  = 15'h4001;
  localparam logic [ADDR_W-1:0] ADDR_TMR_CNT  = 15'h4002;
  localparam logic [ADDR_W-1:0] ADDR_TMR_CMP  = 15'h4003;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 15'h4004;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_EN   = 15'h4005;
  localparam logic [ADDR_W-1:0] ADDR_KBD      = 15'h6000;

  // STATUS bit positions
  localparam int STAT_TMR  = 0;
  localparam int STAT_GPIO = 1;
  localparam int STAT_KBD  = 2;
  localparam int STAT_W    = 3;

  typedef enum logic {
    KBD_EMPTY = 1'b0,
    KBD_FULL  = 1'b1
  } kbd_state_e;

  // RAM is the lower half of the address space
  function automatic logic is_ram(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1] == 1'b0;
  endfunction

endpackage

// File: rtl/mem_io_ctrl_if.sv
// CPU data bus and keyboard producer handshake, bundled for the controller.
interface mem_io_ctrl_if;
  import mem_io_pkg::*;

  logic [ADDR_W-1:0] addressM;
  logic [DATA_W-1:0] outM;
  logic              writeM;
  logic [DATA_W-1:0] inM;
  logic [DATA_W-1:0] kbd_data;
  logic              kbd_valid;
  logic              kbd_ready;

  // CPU and keyboard producer side
  modport master (
    output addressM, outM, writeM, kbd_data, kbd_valid,
    input  inM, kbd_ready
  );

  // Controller side
  modport slave (
    input  addressM, outM, writeM, kbd_data, kbd_valid,
    output inM, kbd_ready
  );

endinterface

// File: rtl/mem_io_ctrl_ram16k.sv
// 16K x 16 data RAM: synchronous write, asynchronous read.
module ram16k
  import mem_io_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // NOTE: the array has no reset; clearing 16K words would force it into
  // flops instead of a RAM macro, and software never relies on its contents.
  logic [DATA_W-1:0] mem [RAM_DEPTH];

  // Write port: commit on the rising edge when enabled
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read port is combinational, so a same-cycle write shows old data
  assign rdata = mem[addr];

endmodule

// File: rtl/mem_io_ctrl.sv
// Memory-mapped I/O controller: RAM, GPIO with synchronizer, free-running
// timer with compare, sticky status/interrupt logic and a one-entry
// keyboard buffer, all decoded from the CPU data bus.
module mem_io_ctrl
  import mem_io_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  mem_io_ctrl_if.slave      bus,
  input  logic [DATA_W-1:0] gpio_in,
  output logic [DATA_W-1:0] gpio_out,
  output logic              irq
);

  logic [DATA_W-1:0] gpio_out_q,  gpio_out_d;
  logic [DATA_W-1:0] sync1_q,     sync1_d;
  logic [DATA_W-1:0] sync2_q,     sync2_d;
  logic [DATA_W-1:0] gpio_prev_q, gpio_prev_d;
  logic [DATA_W-1:0] cnt_q,       cnt_d;
  logic [DATA_W-1:0] cmp_q,       cmp_d;
  logic [1:0]        status_q,    status_d;
  logic [STAT_W-1:0] irq_en_q,    irq_en_d;
  logic [DATA_W-1:0] kbd_code_q,  kbd_code_d;
  kbd_state_e        kbd_state_q, kbd_state_d;

  logic wr_gpio_out, wr_cnt, wr_cmp, wr_status, wr_irq_en, wr_kbd, wr_ram;
  logic tmr_set, gpio_set, kbd_full;
  logic [1:0]        status_clr;
  logic [STAT_W-1:0] status_all;
  logic [DATA_W-1:0] ram_rdata;

  // Write strobes; a RAM write during reset is dropped
  assign wr_gpio_out = bus.writeM && (bus.addressM == ADDR_GPIO_OUT);
  assign wr_cnt      = bus.writeM && (bus.addressM == ADDR_TMR_CNT);
  assign wr_cmp      = bus.writeM && (bus.addressM == ADDR_TMR_CMP);
  assign wr_status   = bus.writeM && (bus.addressM == ADDR_STATUS);
  assign wr_irq_en   = bus.writeM && (bus.addressM == ADDR_IRQ_EN);
  assign wr_kbd      = bus.writeM && (bus.addressM == ADDR_KBD);
  assign wr_ram      = bus.writeM && is_ram(bus.addressM) && reset;

  ram16k u_ram (
    .clk   (clk),
    .we    (wr_ram),
    .addr  (bus.addressM[RAM_AW-1:0]),
    .wdata (bus.outM),
    .rdata (ram_rdata)
  );

  assign kbd_full   = (kbd_state_q == KBD_FULL);
  assign status_all = {kbd_full, status_q};

  // Next-state for GPIO, timer and status registers
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    gpio_out_d  = gpio_out_q;
    cmp_d       = cmp_q;
    irq_en_d    = irq_en_q;
    sync1_d     = gpio_in;
    sync2_d     = sync1_q;
    gpio_prev_d = sync2_q;
    cnt_d       = DATA_W'(cnt_q + 1'b1);
    tmr_set     = (cnt_q == cmp_q);
    gpio_set    = (sync2_q != gpio_prev_q);
    status_clr  = wr_status ? bus.outM[1:0] : 2'b00;

    if (wr_gpio_out) gpio_out_d = bus.outM;
    if (wr_cmp)      cmp_d      = bus.outM;
    if (wr_irq_en)   irq_en_d   = bus.outM[STAT_W-1:0];
    if (wr_cnt)      cnt_d      = bus.outM;

    // Sticky bits: a set event in the same cycle beats a write-1-to-clear
    status_d[STAT_TMR]  = tmr_set  | (status_q[STAT_TMR]  & ~status_clr[STAT_TMR]);
    status_d[STAT_GPIO] = gpio_set | (status_q[STAT_GPIO] & ~status_clr[STAT_GPIO]);
  end

  // Register file update with synchronous active-low reset
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // matching the hardware regardless of statement order.
    if (!reset) begin
      gpio_out_q  <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      gpio_prev_q <= '0;
      cnt_q       <= '0;
      cmp_q       <= '0;
      status_q    <= '0;
      irq_en_q    <= '0;
    end else begin
      gpio_out_q  <= gpio_out_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      gpio_prev_q <= gpio_prev_d;
      cnt_q       <= cnt_d;
      cmp_q       <= cmp_d;
      status_q    <= status_d;
      irq_en_q    <= irq_en_d;
    end
  end

  // Keyboard buffer next-state: capture when empty, pop on CPU write
  always_comb begin
    kbd_state_d = kbd_state_q;
    kbd_code_d  = kbd_code_q;
    case (kbd_state_q)
      KBD_EMPTY: begin
        if (bus.kbd_valid) begin
          kbd_code_d  = bus.kbd_data;
          kbd_state_d = KBD_FULL;
        end
      end
      KBD_FULL: begin
        if (wr_kbd) kbd_state_d = KBD_EMPTY;
      end
      default: kbd_state_d = KBD_EMPTY;
    endcase
  end

  // Keyboard buffer state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      kbd_state_q <= KBD_EMPTY;
      kbd_code_q  <= '0;
    end else begin
      kbd_state_q <= kbd_state_d;
      kbd_code_q  <= kbd_code_d;
    end
  end

  assign bus.kbd_ready = (kbd_state_q == KBD_EMPTY);
  assign gpio_out      = gpio_out_q;
  assign irq           = |(status_all & irq_en_q);

  // Read mux; unmapped addresses return zero
  always_comb begin
    bus.inM = '0;
    if (is_ram(bus.addressM)) begin
      bus.inM = ram_rdata;
    end else begin
      case (bus.addressM)
        ADDR_GPIO_OUT: bus.inM = gpio_out_q;
        ADDR_GPIO_IN:  bus.inM = sync2_q;
        ADDR_TMR_CNT:  bus.inM = cnt_q;
        ADDR_TMR_CMP:  bus.inM = cmp_q;
        ADDR_STATUS:   bus.inM = {{(DATA_W-STAT_W){1'b0}}, status_all};
        ADDR_IRQ_EN:   bus.inM = {{(DATA_W-STAT_W){1'b0}}, irq_en_q};
        ADDR_KBD:      bus.inM = kbd_full ? kbd_code_q : '0;
        default:       bus.inM = '0;
      endcase
    end
  end

endmodule

// File: doc/mem_io_ctrl.md
MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

Interface
REQ-001 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 Port reset, input, 1: synchronous, active-low; sampled on rising clk edge.
REQ-003 Port addressM, input, 15: CPU data address.
REQ-004 Port outM, input, 16: CPU write data.
REQ-005 Port writeM, input, 1: CPU write strobe, active high, one write per cycle.
REQ-006 Port inM, output, 16: read data to CPU, combinational from addressM and current state.
REQ-007 Port gpio_in, input, 16: asynchronous external inputs.
REQ-008 Port gpio_out, output, 16: registered output port.
REQ-009 Port kbd_data, input, 16: key code from producer.
REQ-010 Port kbd_valid, input, 1: producer offers kbd_data.
REQ-011 Port kbd_ready, output, 1: block accepts a code this cycle.
REQ-012 Port irq, output, 1: OR of enabled sticky status bits.

Function
REQ-013 Map: 0x0000-0x3FFF RAM; 0x4000 GPIO_OUT; 0x4001 GPIO_IN; 0x4002 TMR_CNT; 0x4003 TMR_CMP; 0x4004 STATUS; 0x4005 IRQ_EN; 0x6000 KBD.
REQ-014 RAM: 16384x16, write on edge when writeM and address in range, asynchronous read; contents not reset.
REQ-015 Read-during-write same address: inM shows old data that cycle, new data next cycle.
REQ-016 Unmapped addresses: inM = 0x0000, writes ignored.
REQ-017 GPIO_OUT: read/write, drives gpio_out directly.
REQ-018 GPIO_IN: read-only; gpio_in passed through 2-flop synchronizer, read value = second stage; writes ignored.
REQ-019 TMR_CNT: increments by 1 every cycle, wraps 0xFFFF->0x0000; CPU write loads outM instead of incrementing that cycle.
REQ-020 TMR_CMP: read/write; when TMR_CNT (pre-update value) equals TMR_CMP, STATUS[0] sets next cycle.
REQ-021 STATUS: bit0 timer match, bit1 GPIO_IN change (synchronized value differs from previous cycle), bit2 KBD full (live, read-only); bits 15:3 read 0.
REQ-022 STATUS write: write-1-to-clear bits 1:0; a set event in the same cycle wins over the clear.
REQ-023 IRQ_EN: read/write, bits 2:0 used; irq = |(STATUS[2:0] & IRQ_EN[2:0]), registered-free combinational from state.
REQ-024 KBD: one-entry buffer, states EMPTY/FULL; kbd_ready = (state == EMPTY).
REQ-025 EMPTY and kbd_valid: capture kbd_data, go FULL.
REQ-026 KBD read returns held code when FULL, 0x0000 when EMPTY; reads have no side effect.
REQ-027 Any CPU write to 0x6000 when FULL: pop, go EMPTY; write when EMPTY ignored.
REQ-028 Pop and kbd_valid same cycle: kbd_ready is 0 that cycle, so no capture; capture occurs earliest next cycle.

Reset
REQ-029 While reset low at an edge: GPIO_OUT, TMR_CNT, TMR_CMP, STATUS, IRQ_EN, synchronizer flops = 0; KBD state EMPTY, held code 0.
REQ-030 Post-reset outputs: gpio_out=0, kbd_ready=1, irq=0; reset mid-write discards that write (RAM write also suppressed).

Structure
REQ-031 Address constants and STATUS bit indices reside in shared package mem_io_pkg.
REQ-032 RAM is sub-module ram16k (sync write, async read); all registers and decode stay in mem_io_ctrl.

Verification
REQ-033 Write 0x1234 to 0x0005, then read 0x0005 -> inM=0x1234; read 0x4006 -> 0x0000.
REQ-034 Write TMR_CMP=0x0010, TMR_CNT=0x000E -> STATUS[0]=1 three cycles later; with IRQ_EN=1, irq=1; write STATUS=0x0001 -> irq=0 next cycle.
REQ-035 kbd_valid=1, kbd_data=0x0041 -> next cycle KBD reads 0x0041, kbd_ready=0; second code 0x0042 held off; write 0x6000 -> EMPTY, then 0x0042 captured.
REQ-036 gpio_in 0x0000->0x00FF -> GPIO_IN reads 0x00FF after 2 cycles, STATUS[1]=1; clear write concurrent with another toggle -> bit remains 1.
REQ-037 Write TMR_CNT=0xFFFF -> next cycles read 0xFFFF? no: reads 0x0000 one cycle after load value 0xFFFF is visible (wrap).
REQ-038 Assert reset low mid-operation with KBD FULL and gpio_out=0xBEEF -> after edge gpio_out=0, kbd_ready=1, irq=0.
